nv_nvdla_mcif_write_eg_resp: RTL and testbench
==============================================

# nv_nvdla_mcif_write_eg_resp

Parametrised AXI write-response egress for the MCIF write path. Registers every B-channel beat, routes it by AXI ID to one of `NUM_CLIENTS` per-client context queues, pops that queue's entry, and returns the burst length to ingress for outstanding-credit release. It also emits a registered per-client write-complete pulse when the popped entry requests an ack. Relative to the fixed 5-client generation, it adds response-error tracking (BRESP, orphan and out-of-range IDs) with a sticky status capture.

## Interface
- `NUM_CLIENTS`, 5, number of write clients / context queues (1..8)
- `AXI_ID_W`, 8, width of AXI BID
- `CLIENT_ID_W`, 3, low BID bits used as client index; `2**CLIENT_ID_W >= NUM_CLIENTS`
- `LEN_W`, 2, burst-length field width returned to ingress
- `ERR_CNT_W`, 8, width of saturating error counter
- `nvdla_core_clk`  in  1  sole clock
- `nvdla_core_rst`  in  1  asynchronous, active-high reset
- `noc2mcif_axi_b_bvalid`  in  1  B beat valid
- `noc2mcif_axi_b_bready`  out  1  constant 1; no backpressure on B
- `noc2mcif_axi_b_bid`  in  AXI_ID_W  response ID
- `noc2mcif_axi_b_bresp`  in  2  AXI response code
- `cq_rd_pvld`  in  NUM_CLIENTS  per-client queue head valid
- `cq_rd_prdy`  out  NUM_CLIENTS  per-client pop strobe
- `cq_rd_pd`  in  NUM_CLIENTS*(LEN_W+1)  per-client head; slice i = {len[LEN_W:1], require_ack[0]}
- `wr_rsp_complete`  out  NUM_CLIENTS  one-cycle completion pulse per client
- `eg2ig_axi_vld`  out  1  credit-return valid
- `eg2ig_axi_len`  out  LEN_W  credit-return length
- `err_clr`  in  1  clears sticky error status
- `err_vld`  out  1  sticky: an error was captured
- `err_code`  out  2  1=SLVERR, 2=DECERR, 3=orphan/out-of-range
- `err_client`  out  CLIENT_ID_W  client index of the first captured error
- `err_cnt`  out  ERR_CNT_W  saturating count of all errors

## Operation
- Stage 1 (input flop): `iflop_vld` <= `bvalid`. `iflop_id` <= `bid[CLIENT_ID_W-1:0]` and `iflop_resp` <= `bresp`, both loaded only when `bvalid`.
- Decode: `hit[i] = iflop_vld & (iflop_id == i)`. `cq_rd_prdy[i] = hit[i]`, combinational from the flops.
- Out-of-range: `iflop_vld` with `iflop_id >= NUM_CLIENTS` asserts no `prdy` and is classed as an error (code 3).
- Orphan: `hit[i] & !cq_rd_pvld[i]` is classed as an error (code 3) and generates no completion.
- Completion: `wr_rsp_complete[i]` <= `hit[i] & cq_rd_pvld[i] & require_ack[i]`.
- Completion is asserted regardless of BRESP; an erroring response still completes so the client does not hang.
- Credit return: `eg2ig_axi_vld = iflop_vld`. `eg2ig_axi_len` = len of the hit client.
- Credit return on out-of-range or orphan: `vld` stays 1 and `len` = 0.
- Error priority within one beat: code 3 > DECERR(3'b11 resp) > SLVERR(2'b10 resp). OKAY/EXOKAY are not errors.
- Sticky capture: on an error while `err_vld`=0, load `err_code`/`err_client` and set `err_vld`. Later errors do not overwrite the captured values.
- `err_cnt` increments on every error beat and saturates at all-ones.
- `err_clr` clears `err_vld`, `err_code` and `err_client`, and zeroes `err_cnt`.
- Simultaneous `err_clr` and a new error: clear then capture. The result is `err_vld`=1 with the new error and `err_cnt`=1.

## Timing
- B beat accepted in cycle T.
- `cq_rd_prdy` and `eg2ig_axi_vld`/`len` are valid in T+1.
- `wr_rsp_complete` pulses in T+2.
- `err_*` outputs update in T+2.
- Back-to-back B beats are sustained at one per cycle with no bubbles. Each beat pops exactly one entry.
- Reset values: all flops 0; `wr_rsp_complete`=0, `cq_rd_prdy`=0, `eg2ig_axi_vld`=0, `eg2ig_axi_len`=0, `err_*`=0. `bready`=1 during and after reset.
- A beat in flight at reset assertion is dropped: no pop, no completion, no credit.
- `eg2ig_axi_len` is 0 whenever `eg2ig_axi_vld`=0 (no X propagation).

## Configuration
- `NVDLA_MCIF_WR_RESP_ERR_EN` defined: BRESP flop, error classification, sticky capture and `err_cnt` are present as described above.
- Not defined: BRESP is ignored; `err_vld`/`err_code`/`err_client`/`err_cnt` are tied to 0 and `err_clr` is unused.
- Without the macro, orphan/out-of-range beats still suppress the pop/completion and return `len`=0.

## Test plan
- Client 1, head {len=2, ack=1}, BID=0x01, OKAY: `prdy[1]` at T+1, `eg2ig_len`=2, `wr_rsp_complete[1]` at T+2, no error.
- BID=0x03 and BID=0x00 on consecutive cycles with both heads {len=1, ack=0}: two pops in consecutive cycles, two credits, no completions.
- BID=0x02 with BRESP=SLVERR, then BID=0x04 with DECERR: `err_vld`=1, `err_code`=1, `err_client`=2, `err_cnt`=2; both completions still fire if ack=1.
- BID=0x07 (out of range) at `NUM_CLIENTS`=5, then BID=0x00 with `cq_rd_pvld[0]`=0: no `prdy`, `eg2ig_len`=0 both times, `err_code`=3, `err_cnt`=2.
- Drive 300 SLVERR beats with `ERR_CNT_W`=8: `err_cnt` holds at 255. Then `err_clr` coincident with an error: `err_cnt`=1, `err_vld`=1.
- Assert reset the cycle after a B beat: no `prdy`, completion or credit; all outputs 0, `bready`=1.

Source files
------------

// File: rtl/nv_nvdla_mcif_write_eg_resp.sv
// MCIF write-response egress: registers B beats, pops the matching client context queue,
// returns credits and pulses write-complete. Optional error tracking under NVDLA_MCIF_WR_RESP_ERR_EN.
module nv_nvdla_mcif_write_eg_resp #(
   parameter int NUM_CLIENTS = 5,
   parameter int AXI_ID_W    = 8,
   parameter int CLIENT_ID_W = 3,
   parameter int LEN_W       = 2,
   parameter int ERR_CNT_W   = 8
) (
   input  logic                               nvdla_core_clk,
   input  logic                               nvdla_core_rst,
   input  logic                               noc2mcif_axi_b_bvalid,
   output logic                               noc2mcif_axi_b_bready,
   input  logic [AXI_ID_W-1:0]                noc2mcif_axi_b_bid,
   input  logic [1:0]                         noc2mcif_axi_b_bresp,
   input  logic [NUM_CLIENTS-1:0]             cq_rd_pvld,
   output logic [NUM_CLIENTS-1:0]             cq_rd_prdy,
   input  logic [NUM_CLIENTS*(LEN_W+1)-1:0]   cq_rd_pd,
   output logic [NUM_CLIENTS-1:0]             wr_rsp_complete,
   output logic                               eg2ig_axi_vld,
   output logic [LEN_W-1:0]                   eg2ig_axi_len,
   input  logic                               err_clr,
   output logic                               err_vld,
   output logic [1:0]                         err_code,
   output logic [CLIENT_ID_W-1:0]             err_client,
   output logic [ERR_CNT_W-1:0]               err_cnt
);

   localparam int PD_W = LEN_W + 1;

   logic                   iflopVld_q;
   logic [CLIENT_ID_W-1:0] iflopId_q;
   logic [NUM_CLIENTS-1:0] hit;
   logic [NUM_CLIENTS-1:0] pop;
   logic [NUM_CLIENTS-1:0] complete_d;
   logic [NUM_CLIENTS-1:0] complete_q;
   logic [LEN_W-1:0]       lenSel;
   logic                   outOfRange;
   logic                   orphan;
   logic                   badId;
   logic                   unusedBidHi;

   assign noc2mcif_axi_b_bready = 1'b1;
   assign unusedBidHi = ^noc2mcif_axi_b_bid[AXI_ID_W-1:CLIENT_ID_W];

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         iflopVld_q <= 1'b0;
         iflopId_q  <= '0;
      end else begin
         iflopVld_q <= noc2mcif_axi_b_bvalid;
         if (noc2mcif_axi_b_bvalid) begin
            iflopId_q <= noc2mcif_axi_b_bid[CLIENT_ID_W-1:0];
         end
      end
   end

   // Only a hit on a non-empty queue pops; orphans and out-of-range IDs return a zero-length credit.
   always_comb begin
      hit        = '0;
      pop        = '0;
      complete_d = '0;
      lenSel     = '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         hit[i]        = iflopVld_q && (iflopId_q == CLIENT_ID_W'(i));
         pop[i]        = hit[i] & cq_rd_pvld[i];
         complete_d[i] = pop[i] & cq_rd_pd[i*PD_W];
         if (pop[i]) begin
            lenSel = lenSel | cq_rd_pd[i*PD_W+1 +: LEN_W];
         end
      end
   end

   assign outOfRange = iflopVld_q && (32'(iflopId_q) >= NUM_CLIENTS);
   assign orphan     = |(hit & ~cq_rd_pvld);
   assign badId      = outOfRange | orphan;

   assign cq_rd_prdy    = pop;
   assign eg2ig_axi_vld = iflopVld_q;
   assign eg2ig_axi_len = lenSel;

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         complete_q <= '0;
      end else begin
         complete_q <= complete_d;
      end
   end

   assign wr_rsp_complete = complete_q;

`ifdef NVDLA_MCIF_WR_RESP_ERR_EN
   logic [1:0]             iflopResp_q;
   logic [1:0]             beatCode;
   logic                   beatErr;
   logic                   errVld_q;
   logic [1:0]             errCode_q;
   logic [CLIENT_ID_W-1:0] errClient_q;
   logic [ERR_CNT_W-1:0]   errCnt_q;

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         iflopResp_q <= '0;
      end else if (noc2mcif_axi_b_bvalid) begin
         iflopResp_q <= noc2mcif_axi_b_bresp;
      end
   end

   always_comb begin
      beatCode = 2'd0;
      if (badId) begin
         beatCode = 2'd3;
      end else if (iflopResp_q == 2'b11) begin
         beatCode = 2'd2;
      end else if (iflopResp_q == 2'b10) begin
         beatCode = 2'd1;
      end
   end

   assign beatErr = iflopVld_q && (beatCode != 2'd0);

   // A clear in the same cycle as a new error wipes the old state first, so the new error is captured.
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         errVld_q    <= 1'b0;
         errCode_q   <= '0;
         errClient_q <= '0;
         errCnt_q    <= '0;
      end else begin
         if (err_clr) begin
            errVld_q    <= 1'b0;
            errCode_q   <= '0;
            errClient_q <= '0;
            errCnt_q    <= '0;
         end
         if (beatErr) begin
            if (err_clr || !errVld_q) begin
               errVld_q    <= 1'b1;
               errCode_q   <= beatCode;
               errClient_q <= iflopId_q;
            end
            if (err_clr) begin
               errCnt_q <= ERR_CNT_W'(1);
            end else if (errCnt_q != '1) begin
               errCnt_q <= errCnt_q + ERR_CNT_W'(1);
            end
         end
      end
   end

   assign err_vld    = errVld_q;
   assign err_code   = errCode_q;
   assign err_client = errClient_q;
   assign err_cnt    = errCnt_q;
`else
   logic unusedErrIn;

   assign unusedErrIn = ^{noc2mcif_axi_b_bresp, err_clr};
   assign err_vld     = 1'b0;
   assign err_code    = '0;
   assign err_client  = '0;
   assign err_cnt     = '0;
`endif

endmodule

// File: tb/tb_nv_nvdla_mcif_write_eg_resp.sv
// Directed self-checking bench for nv_nvdla_mcif_write_eg_resp; error expectations follow
// NVDLA_MCIF_WR_RESP_ERR_EN (tied-zero when undefined).
module tb_nv_nvdla_mcif_write_eg_resp;

   localparam int NC = 5;
   localparam int AW = 8;
   localparam int CW = 3;
   localparam int LW = 2;
   localparam int EW = 8;
   localparam int PW = LW + 1;
`ifdef NVDLA_MCIF_WR_RESP_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic             clk;
   logic             rst;
   logic             bvalid;
   logic             bready;
   logic [AW-1:0]    bid;
   logic [1:0]       bresp;
   logic [NC-1:0]    pvld;
   logic [NC-1:0]    prdy;
   logic [NC*PW-1:0] pd;
   logic [NC-1:0]    complete;
   logic             igVld;
   logic [LW-1:0]    igLen;
   logic             errClr;
   logic             errVld;
   logic [1:0]       errCode;
   logic [CW-1:0]    errClient;
   logic [EW-1:0]    errCnt;

   int checks   = 0;
   int failures = 0;

   nv_nvdla_mcif_write_eg_resp #(
      .NUM_CLIENTS(NC), .AXI_ID_W(AW), .CLIENT_ID_W(CW), .LEN_W(LW), .ERR_CNT_W(EW)
   ) dut (
      .nvdla_core_clk        (clk),
      .nvdla_core_rst        (rst),
      .noc2mcif_axi_b_bvalid (bvalid),
      .noc2mcif_axi_b_bready (bready),
      .noc2mcif_axi_b_bid    (bid),
      .noc2mcif_axi_b_bresp  (bresp),
      .cq_rd_pvld            (pvld),
      .cq_rd_prdy            (prdy),
      .cq_rd_pd              (pd),
      .wr_rsp_complete       (complete),
      .eg2ig_axi_vld         (igVld),
      .eg2ig_axi_len         (igLen),
      .err_clr               (errClr),
      .err_vld               (errVld),
      .err_code              (errCode),
      .err_client            (errClient),
      .err_cnt               (errCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkErr(input string tag, input logic v, input logic [1:0] code,
                           input logic [CW-1:0] client, input logic [EW-1:0] cnt);
      checkOutput({tag, ".errVld"},    32'(errVld),    ERR_EN ? 32'(v) : 32'd0);
      checkOutput({tag, ".errCode"},   32'(errCode),   ERR_EN ? 32'(code) : 32'd0);
      checkOutput({tag, ".errClient"}, 32'(errClient), ERR_EN ? 32'(client) : 32'd0);
      checkOutput({tag, ".errCnt"},    32'(errCnt),    ERR_EN ? 32'(cnt) : 32'd0);
   endtask

   task automatic checkCredit(input string tag, input logic [NC-1:0] expPrdy,
                              input logic expVld, input logic [LW-1:0] expLen);
      checkOutput({tag, ".prdy"}, 32'(prdy), 32'(expPrdy));
      checkOutput({tag, ".vld"},  32'(igVld), 32'(expVld));
      checkOutput({tag, ".len"},  32'(igLen), 32'(expLen));
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [AW-1:0] id, input logic [1:0] resp);
      bvalid = v;
      bid    = id;
      bresp  = resp;
   endtask

   task automatic setHead(input int c, input logic [LW-1:0] len, input logic ack, input logic pv);
      pd[c*PW +: PW] = {len, ack};
      pvld[c]        = pv;
   endtask

   initial begin
      rst    = 1'b1;
      errClr = 1'b0;
      pvld   = '0;
      pd     = '0;
      applyStimulus(1'b0, '0, 2'b00);
      cycle();
      cycle();

      // Reset state
      checkOutput("rst.bready", 32'(bready), 32'd1);
      checkCredit("rst", 5'b00000, 1'b0, 2'd0);
      checkOutput("rst.complete", 32'(complete), 32'd0);
      checkErr("rst", 1'b0, 2'd0, 3'd0, 8'd0);
      rst = 1'b0;
      cycle();
      checkOutput("postrst.bready", 32'(bready), 32'd1);

      // Single beat to client 1 with ack
      setHead(1, 2'd2, 1'b1, 1'b1);
      applyStimulus(1'b1, 8'h01, 2'b00);
      cycle();
      applyStimulus(1'b0, '0, 2'b00);
      checkCredit("t1.T1", 5'b00010, 1'b1, 2'd2);
      checkOutput("t1.T1.complete", 32'(complete), 32'd0);
      cycle();
      checkOutput("t1.T2.complete", 32'(complete), 32'b00010);
      checkCredit("t1.T2", 5'b00000, 1'b0, 2'd0);
      checkErr("t1", 1'b0, 2'd0, 3'd0, 8'd0);

      // Back-to-back beats to clients 3 then 0, no ack
      setHead(1, 2'd0, 1'b0, 1'b0);
      setHead(3, 2'd1, 1'b0, 1'b1);
      setHead(0, 2'd1, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h03, 2'b00);
      cycle();
      applyStimulus(1'b1, 8'h00, 2'b00);
      checkCredit("t2.b0", 5'b01000, 1'b1, 2'd1);
      cycle();
      applyStimulus(1'b0, '0, 2'b00);
      checkCredit("t2.b1", 5'b00001, 1'b1, 2'd1);
      checkOutput("t2.b1.complete", 32'(complete), 32'd0);
      cycle();
      checkCredit("t2.idle", 5'b00000, 1'b0, 2'd0);
      checkOutput("t2.idle.complete", 32'(complete), 32'd0);

      // SLVERR on client 2 then DECERR on client 4; completions still fire
      setHead(3, 2'd0, 1'b0, 1'b0);
      setHead(0, 2'd0, 1'b0, 1'b0);
      setHead(2, 2'd1, 1'b1, 1'b1);
      setHead(4, 2'd3, 1'b1, 1'b1);
      applyStimulus(1'b1, 8'h02, 2'b10);
      cycle();
      applyStimulus(1'b1, 8'h04, 2'b11);
      checkCredit("t3.b0", 5'b00100, 1'b1, 2'd1);
      cycle();
      applyStimulus(1'b0, '0, 2'b00);
      checkCredit("t3.b1", 5'b10000, 1'b1, 2'd3);
      checkOutput("t3.b0.complete", 32'(complete), 32'b00100);
      checkErr("t3.e0", 1'b1, 2'd1, 3'd2, 8'd1);
      cycle();
      checkOutput("t3.b1.complete", 32'(complete), 32'b10000);
      checkErr("t3.e1", 1'b1, 2'd1, 3'd2, 8'd2);

      // Clear, then out-of-range ID 7 and orphan on client 0
      errClr = 1'b1;
      cycle();
      errClr = 1'b0;
      checkErr("t4.clr", 1'b0, 2'd0, 3'd0, 8'd0);
      setHead(2, 2'd0, 1'b0, 1'b0);
      setHead(4, 2'd0, 1'b0, 1'b0);
      setHead(0, 2'd3, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'h07, 2'b00);
      cycle();
      applyStimulus(1'b1, 8'h00, 2'b00);
      checkCredit("t4.oor", 5'b00000, 1'b1, 2'd0);
      cycle();
      applyStimulus(1'b0, '0, 2'b00);
      checkCredit("t4.orphan", 5'b00000, 1'b1, 2'd0);
      checkOutput("t4.oor.complete", 32'(complete), 32'd0);
      checkErr("t4.e0", 1'b1, 2'd3, 3'd7, 8'd1);
      cycle();
      checkOutput("t4.orphan.complete", 32'(complete), 32'd0);
      checkErr("t4.e1", 1'b1, 2'd3, 3'd7, 8'd2);

      // 300 back-to-back SLVERR beats saturate the counter
      errClr = 1'b1;
      setHead(0, 2'd0, 1'b0, 1'b0);
      setHead(1, 2'd1, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h01, 2'b10);
      cycle();
      errClr = 1'b0;
      repeat (299) cycle();
      applyStimulus(1'b0, '0, 2'b00);
      checkCredit("t5.last", 5'b00010, 1'b1, 2'd1);
      cycle();
      cycle();
      checkErr("t5.sat", 1'b1, 2'd1, 3'd1, 8'd255);

      // Clear coincident with a new DECERR on client 3
      setHead(3, 2'd1, 1'b1, 1'b1);
      applyStimulus(1'b1, 8'h03, 2'b11);
      cycle();
      applyStimulus(1'b0, '0, 2'b00);
      errClr = 1'b1;
      checkCredit("t5.clrbeat", 5'b01000, 1'b1, 2'd1);
      cycle();
      errClr = 1'b0;
      checkOutput("t5.clrbeat.complete", 32'(complete), 32'b01000);
      checkErr("t5.clrcap", 1'b1, 2'd2, 3'd3, 8'd1);

      // Reset while a beat sits in the input flop drops it
      setHead(3, 2'd0, 1'b0, 1'b0);
      setHead(1, 2'd2, 1'b1, 1'b1);
      applyStimulus(1'b1, 8'h01, 2'b00);
      cycle();
      applyStimulus(1'b0, '0, 2'b00);
      rst = 1'b1;
      #1;
      checkCredit("t6.rst", 5'b00000, 1'b0, 2'd0);
      checkOutput("t6.rst.bready", 32'(bready), 32'd1);
      cycle();
      checkOutput("t6.rst.complete", 32'(complete), 32'd0);
      checkErr("t6.rst", 1'b0, 2'd0, 3'd0, 8'd0);
      rst = 1'b0;
      cycle();

      // Normal operation resumes after reset
      applyStimulus(1'b1, 8'h01, 2'b00);
      cycle();
      applyStimulus(1'b0, '0, 2'b00);
      checkCredit("t6.resume", 5'b00010, 1'b1, 2'd2);
      cycle();
      checkOutput("t6.resume.complete", 32'(complete), 32'b00010);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
